// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer for the 10-bit Processing_Unit datapath.
// Define CTRL_ILLEGAL_HALT_EN to halt on opcodes 10-14; otherwise they execute as a one-word NOP.
module control_unit #(
  parameter int word_size = 10,
  parameter int op_size   = 4,
  parameter int Sel1_size = 3,
  parameter int Sel2_size = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [word_size-1:0] instruction,
  input  logic                 Zflag,
  output logic                 Load_R0,
  output logic                 Load_R1,
  output logic                 Load_R2,
  output logic                 Load_R3,
  output logic                 Load_PC,
  output logic                 Inc_PC,
  output logic [Sel1_size-1:0] Sel_Bus_1a_Mux,
  output logic [Sel1_size-1:0] Sel_Bus_1b_Mux,
  output logic [Sel2_size-1:0] Sel_Bus_2_Mux,
  output logic                 Load_IR,
  output logic                 Load_Add_R,
  output logic                 Load_Reg_Z,
  output logic                 write,
  output logic                 halted,
  output logic [3:0]           state_dbg
);

  typedef enum logic [3:0] {
    S_idle, S_fet1, S_fet2, S_dec, S_ex1,
    S_rd1, S_rd2, S_rd3, S_wr1, S_wr2, S_wr3,
    S_br1, S_br2, S_halt
  } state_t;

  localparam logic [op_size-1:0] OP_ADD  = 4'd0;
  localparam logic [op_size-1:0] OP_SUB  = 4'd1;
  localparam logic [op_size-1:0] OP_AND  = 4'd2;
  localparam logic [op_size-1:0] OP_NOT  = 4'd3;
  localparam logic [op_size-1:0] OP_LDI  = 4'd4;
  localparam logic [op_size-1:0] OP_LD   = 4'd5;
  localparam logic [op_size-1:0] OP_ST   = 4'd6;
  localparam logic [op_size-1:0] OP_BR   = 4'd7;
  localparam logic [op_size-1:0] OP_BRZ  = 4'd8;
  localparam logic [op_size-1:0] OP_MOV  = 4'd9;
  localparam logic [op_size-1:0] OP_HALT = 4'd15;

  localparam logic [Sel1_size-1:0] SEL1_PC  = Sel1_size'(4);
  localparam logic [Sel2_size-1:0] SEL2_ALU = Sel2_size'(0);
  localparam logic [Sel2_size-1:0] SEL2_B1A = Sel2_size'(1);
  localparam logic [Sel2_size-1:0] SEL2_MEM = Sel2_size'(2);

  state_t state, state_nxt;

  logic [op_size-1:0] opcode;
  logic [1:0]         dest, src_a, src_b;
  logic [3:0]         load_r;
  logic               is_alu;

  assign opcode = instruction[word_size-1 -: op_size];
  assign dest   = instruction[5:4];
  assign src_a  = instruction[3:2];
  assign src_b  = instruction[1:0];
  assign is_alu = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                  (opcode == OP_AND) || (opcode == OP_NOT);

  assign Load_R0   = load_r[0];
  assign Load_R1   = load_r[1];
  assign Load_R2   = load_r[2];
  assign Load_R3   = load_r[3];
  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_idle;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    load_r         = 4'b0000;
    Load_PC        = 1'b0;
    Inc_PC         = 1'b0;
    Sel_Bus_1a_Mux = '0;
    Sel_Bus_1b_Mux = '0;
    Sel_Bus_2_Mux  = '0;
    Load_IR        = 1'b0;
    Load_Add_R     = 1'b0;
    Load_Reg_Z     = 1'b0;
    write          = 1'b0;
    halted         = 1'b0;
    case (state)
      S_idle: state_nxt = S_fet1;
      // PC onto Add_R: shared by fetch and every operand-word read
      S_fet1, S_rd1, S_wr1, S_br1: begin
        Sel_Bus_1a_Mux = SEL1_PC;
        Sel_Bus_2_Mux  = SEL2_B1A;
        Load_Add_R     = 1'b1;
        case (state)
          S_fet1:  state_nxt = S_fet2;
          S_rd1:   state_nxt = (opcode == OP_LD) ? S_rd2 : S_rd3;
          S_wr1:   state_nxt = S_wr2;
          default: state_nxt = S_br2;
        endcase
      end
      S_fet2: begin
        Sel_Bus_2_Mux = SEL2_MEM;
        Load_IR       = 1'b1;
        Inc_PC        = 1'b1;
        state_nxt     = S_dec;
      end
      S_dec: begin
        Sel_Bus_1a_Mux = Sel1_size'(src_a);
        Sel_Bus_1b_Mux = Sel1_size'(src_b);
        if (is_alu || opcode == OP_MOV)           state_nxt = S_ex1;
        else if (opcode == OP_LDI || opcode == OP_LD) state_nxt = S_rd1;
        else if (opcode == OP_ST)                 state_nxt = S_wr1;
        else if (opcode == OP_BR)                 state_nxt = S_br1;
        else if (opcode == OP_BRZ) begin
          if (Zflag) state_nxt = S_br1;
          else begin
            Inc_PC    = 1'b1;
            state_nxt = S_fet1;
          end
        end
        else if (opcode == OP_HALT)               state_nxt = S_halt;
        else begin
`ifdef CTRL_ILLEGAL_HALT_EN
          state_nxt = S_halt;
`else
          state_nxt = S_fet1;
`endif
        end
      end
      S_ex1: begin
        Sel_Bus_1a_Mux = Sel1_size'(src_a);
        Sel_Bus_1b_Mux = Sel1_size'(src_b);
        load_r         = 4'b0001 << dest;
        if (is_alu) begin
          Sel_Bus_2_Mux = SEL2_ALU;
          Load_Reg_Z    = 1'b1;
        end else begin
          Sel_Bus_2_Mux = SEL2_B1A;
        end
        state_nxt = S_fet1;
      end
      // Operand word becomes the address; PC steps past it
      S_rd2, S_wr2: begin
        Sel_Bus_2_Mux = SEL2_MEM;
        Load_Add_R    = 1'b1;
        Inc_PC        = 1'b1;
        state_nxt     = (state == S_rd2) ? S_rd3 : S_wr3;
      end
      S_rd3: begin
        Sel_Bus_2_Mux = SEL2_MEM;
        load_r        = 4'b0001 << dest;
        Inc_PC        = (opcode == OP_LDI);
        state_nxt     = S_fet1;
      end
      S_wr3: begin
        Sel_Bus_1a_Mux = Sel1_size'(src_a);
        write          = 1'b1;
        state_nxt      = S_fet1;
      end
      S_br2: begin
        Sel_Bus_2_Mux = SEL2_MEM;
        Load_PC       = 1'b1;
        state_nxt     = S_fet1;
      end
      S_halt: halted = 1'b1;
      default: state_nxt = S_idle;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks each instruction class cycle by cycle
// and compares the packed strobe/select vector against hand-derived values.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] instruction;
  logic       Zflag;
  logic       Load_R0, Load_R1, Load_R2, Load_R3, Load_PC, Inc_PC;
  logic [2:0] Sel_Bus_1a_Mux, Sel_Bus_1b_Mux, Sel_Bus_2_Mux;
  logic       Load_IR, Load_Add_R, Load_Reg_Z, write, halted;
  logic [3:0] state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  control_unit dut (
    .clk(clk), .rst(rst), .instruction(instruction), .Zflag(Zflag),
    .Load_R0(Load_R0), .Load_R1(Load_R1), .Load_R2(Load_R2), .Load_R3(Load_R3),
    .Load_PC(Load_PC), .Inc_PC(Inc_PC),
    .Sel_Bus_1a_Mux(Sel_Bus_1a_Mux), .Sel_Bus_1b_Mux(Sel_Bus_1b_Mux),
    .Sel_Bus_2_Mux(Sel_Bus_2_Mux), .Load_IR(Load_IR), .Load_Add_R(Load_Add_R),
    .Load_Reg_Z(Load_Reg_Z), .write(write), .halted(halted), .state_dbg(state_dbg)
  );

  // clock/reset
  always #5 clk = ~clk;

  // {Load_R3..R0, Load_PC, Inc_PC, Sel1a, Sel1b, Sel2, Load_IR, Load_Add_R, Load_Reg_Z, write, halted}
  logic [19:0] pack;
  assign pack = {Load_R3, Load_R2, Load_R1, Load_R0, Load_PC, Inc_PC,
                 Sel_Bus_1a_Mux, Sel_Bus_1b_Mux, Sel_Bus_2_Mux,
                 Load_IR, Load_Add_R, Load_Reg_Z, write, halted};

  function automatic logic [19:0] ctl(input logic [3:0] ldr, input logic ldpc,
                                      input logic inc, input logic [2:0] s1a,
                                      input logic [2:0] s1b, input logic [2:0] s2,
                                      input logic ir, input logic ar, input logic z,
                                      input logic wr, input logic h);
    return {ldr, ldpc, inc, s1a, s1b, s2, ir, ar, z, wr, h};
  endfunction

  logic [19:0] F1, F2, IDLE;
  initial begin
    F1   = ctl(4'b0000, 0, 0, 3'd4, 3'd0, 3'd1, 0, 1, 0, 0, 0);
    F2   = ctl(4'b0000, 0, 1, 3'd0, 3'd0, 3'd2, 1, 0, 0, 0, 0);
    IDLE = 20'd0;
  end

  task automatic check_eq(input string tag, input logic [19:0] got, input logic [19:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %05h expected %05h", tag, got, exp);
    end
  endtask

  // driver: called just after a rising edge; samples on the falling edge
  task automatic expect_cyc(input string tag, input logic [19:0] exp);
    @(negedge clk);
    check_eq(tag, pack, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1 check_eq({tag, "_rst_now"}, pack, IDLE);
    @(posedge clk);
    #1 rst = 1'b0;
    expect_cyc({tag, "_idle"}, IDLE);
  endtask

  initial begin
    rst         = 1'b1;
    instruction = 10'd0;
    Zflag       = 1'b0;
    #1 check_eq("reset", pack, IDLE);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    expect_cyc("idle_after_rst", IDLE);

    // ADD R2 <- R1 + R2
    instruction = 10'b0000_10_01_10;
    expect_cyc("add_fet1", F1);
    expect_cyc("add_fet2", F2);
    expect_cyc("add_dec", ctl(4'b0000, 0, 0, 3'd1, 3'd2, 3'd0, 0, 0, 0, 0, 0));
    expect_cyc("add_ex1", ctl(4'b0100, 0, 0, 3'd1, 3'd2, 3'd0, 0, 0, 1, 0, 0));

    // SUB R1 <- R2 - R3
    instruction = 10'b0001_01_10_11;
    expect_cyc("sub_fet1", F1);
    expect_cyc("sub_fet2", F2);
    expect_cyc("sub_dec", ctl(4'b0000, 0, 0, 3'd2, 3'd3, 3'd0, 0, 0, 0, 0, 0));
    expect_cyc("sub_ex1", ctl(4'b0010, 0, 0, 3'd2, 3'd3, 3'd0, 0, 0, 1, 0, 0));

    // MOV R0 <- R3: Bus_1a path, Z untouched
    instruction = 10'b1001_00_11_00;
    expect_cyc("mov_fet1", F1);
    expect_cyc("mov_fet2", F2);
    expect_cyc("mov_dec", ctl(4'b0000, 0, 0, 3'd3, 3'd0, 3'd0, 0, 0, 0, 0, 0));
    expect_cyc("mov_ex1", ctl(4'b0001, 0, 0, 3'd3, 3'd0, 3'd1, 0, 0, 0, 0, 0));

    // LDI R3, 0x5A
    instruction = 10'b0100_11_00_00;
    expect_cyc("ldi_fet1", F1);
    expect_cyc("ldi_fet2", F2);
    expect_cyc("ldi_dec", IDLE);
    expect_cyc("ldi_rd1", F1);
    expect_cyc("ldi_rd3", ctl(4'b1000, 0, 1, 3'd0, 3'd0, 3'd2, 0, 0, 0, 0, 0));

    // BRZ not taken
    instruction = 10'b1000_00_00_00;
    Zflag       = 1'b0;
    expect_cyc("brz_nt_fet1", F1);
    expect_cyc("brz_nt_fet2", F2);
    expect_cyc("brz_nt_dec", ctl(4'b0000, 0, 1, 3'd0, 3'd0, 3'd0, 0, 0, 0, 0, 0));

    // BRZ taken
    Zflag = 1'b1;
    expect_cyc("brz_t_fet1", F1);
    expect_cyc("brz_t_fet2", F2);
    expect_cyc("brz_t_dec", IDLE);
    expect_cyc("brz_t_br1", F1);
    expect_cyc("brz_t_br2", ctl(4'b0000, 1, 0, 3'd0, 3'd0, 3'd2, 0, 0, 0, 0, 0));
    Zflag = 1'b0;

    // ST R1 -> [0x10]; write for exactly one cycle
    instruction = 10'b0110_00_01_00;
    expect_cyc("st_fet1", F1);
    expect_cyc("st_fet2", F2);
    expect_cyc("st_dec", ctl(4'b0000, 0, 0, 3'd1, 3'd0, 3'd0, 0, 0, 0, 0, 0));
    expect_cyc("st_wr1", F1);
    expect_cyc("st_wr2", ctl(4'b0000, 0, 1, 3'd0, 3'd0, 3'd2, 0, 1, 0, 0, 0));
    expect_cyc("st_wr3", ctl(4'b0000, 0, 0, 3'd1, 3'd0, 3'd0, 0, 0, 0, 1, 0));

    // LD R0, reset pulse in rd2
    instruction = 10'b0101_00_00_00;
    expect_cyc("st_then_fet1", F1);
    expect_cyc("ld_fet2", F2);
    expect_cyc("ld_dec", IDLE);
    expect_cyc("ld_rd1", F1);
    @(negedge clk);
    check_eq("ld_rd2", pack, ctl(4'b0000, 0, 1, 3'd0, 3'd0, 3'd2, 0, 1, 0, 0, 0));
    #1 rst = 1'b1;
    #1 check_eq("ld_rst_async", pack, IDLE);
    @(posedge clk);
    #1 rst = 1'b0;
    expect_cyc("ld_rst_idle", IDLE);
    expect_cyc("ld_rst_fet1", F1);

    // illegal opcode 1010
    instruction = 10'b1010_00_00_00;
    expect_cyc("ill_fet2", F2);
    expect_cyc("ill_dec", IDLE);
`ifdef CTRL_ILLEGAL_HALT_EN
    for (int i = 0; i < 20; i++)
      expect_cyc("ill_halted", ctl(4'b0000, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0, 0, 1));
`else
    expect_cyc("ill_nop_fet1", F1);
`endif
    do_reset("ill");

    // HALT, then reset out of S_halt
    instruction = 10'b1111_00_00_00;
    expect_cyc("halt_fet1", F1);
    expect_cyc("halt_fet2", F2);
    expect_cyc("halt_dec", IDLE);
    for (int i = 0; i < 5; i++)
      expect_cyc("halt_state", ctl(4'b0000, 0, 0, 3'd0, 3'd0, 3'd0, 0, 0, 0, 0, 1));
    do_reset("halt");
    expect_cyc("post_halt_fet1", F1);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
